// File: rtl/sha_pad.sv
// SHA message front end: packs a byte stream into Nl-byte blocks, applies the
// 0x80 / zero-fill / big-endian bit-length padding and hands blocks downstream.
module sha_pad #(
  parameter int Nl = 64,
  parameter int Nm = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  input  logic                  Byte_Last,
  input  logic                  Msg_Empty,
  output logic                  Byte_Ready,
  output logic [0:Nl-1][7:0]    Data_Block,
  output logic                  Enable,
  output logic                  Function,
  input  logic                  Ready
);

  localparam int PW     = $clog2(Nl) + 1;
  localparam int LB     = Nm / 8;
  localparam int LSTART = Nl - LB;

  typedef enum logic [2:0] {FILL, PAD, ZERO, LEN, SEND} state_e;

  state_e               state_q, state_d;
  logic [0:Nl-1][7:0]   blk_q, blk_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [Nm-1:0]        bitlen_q, bitlen_d;
  logic                 first_q, first_d;
  logic                 lenpend_q, lenpend_d;
  logic                 final_q, final_d;
  logic                 padpend_q, padpend_d;
  logic                 rdy_en_q, rdy_en_d;
  logic [PW-1:0]        ptr_inc;
  logic [PW-2:0]        idx;

  assign ptr_inc = ptr_q + PW'(1);
  assign idx     = ptr_q[PW-2:0];

  // rdy_en keeps Byte_Ready low while reset is held, without an input-to-output path
  assign Byte_Ready = rdy_en_q && (state_q == FILL);
  assign Enable     = (state_q == SEND);
  assign Function   = ~first_q;
  assign Data_Block = blk_q;

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    ptr_d     = ptr_q;
    bitlen_d  = bitlen_q;
    first_d   = first_q;
    lenpend_d = lenpend_q;
    final_d   = final_q;
    padpend_d = padpend_q;
    rdy_en_d  = 1'b1;
    case (state_q)
      FILL: begin
        if (Byte_Valid && Byte_Ready) begin
          blk_d[idx] = Byte_In;
          ptr_d      = ptr_inc;
          bitlen_d   = bitlen_q + Nm'(8);
          // a last byte that fills the block must ship it before padding starts
          if (Byte_Last && ptr_inc == PW'(Nl)) begin
            padpend_d = 1'b1;
            state_d   = SEND;
          end else if (Byte_Last) begin
            state_d = PAD;
          end else if (ptr_inc == PW'(Nl)) begin
            state_d = SEND;
          end
        end else if (Msg_Empty && ptr_q == '0 && first_q) begin
          state_d = PAD;
        end
      end
      PAD: begin
        blk_d[idx] = 8'h80;
        ptr_d      = ptr_inc;
        lenpend_d  = 1'b1;
        if (ptr_inc == PW'(LSTART))  state_d = LEN;
        else if (ptr_inc == PW'(Nl)) state_d = SEND;
        else                         state_d = ZERO;
      end
      ZERO: begin
        blk_d[idx] = 8'h00;
        ptr_d      = ptr_inc;
        if (ptr_inc == PW'(LSTART) && lenpend_q) state_d = LEN;
        else if (ptr_inc == PW'(Nl))             state_d = SEND;
      end
      LEN: begin
        blk_d[LSTART:Nl-1] = bitlen_q;
        final_d            = 1'b1;
        state_d            = SEND;
      end
      SEND: begin
        if (Ready) begin
          first_d = 1'b0;
          ptr_d   = '0;
          if (final_q) begin
            bitlen_d  = '0;
            first_d   = 1'b1;
            lenpend_d = 1'b0;
            final_d   = 1'b0;
            blk_d     = '0;
            state_d   = FILL;
          end else if (padpend_q) begin
            padpend_d = 1'b0;
            blk_d     = '0;
            state_d   = PAD;
          end else if (lenpend_q) begin
            blk_d   = '0;
            state_d = ZERO;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      blk_q     <= '0;
      ptr_q     <= '0;
      bitlen_q  <= '0;
      first_q   <= 1'b1;
      lenpend_q <= 1'b0;
      final_q   <= 1'b0;
      padpend_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      ptr_q     <= ptr_d;
      bitlen_q  <= bitlen_d;
      first_q   <= first_d;
      lenpend_q <= lenpend_d;
      final_q   <= final_d;
      padpend_q <= padpend_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_sha_pad.sv
// Directed bench for sha_pad: hand-built expected blocks for the padding cases.
module tb_sha_pad;

  logic             clk;
  logic             rst;
  logic [7:0]       Byte_In;
  logic             Byte_Valid;
  logic             Byte_Last;
  logic             Msg_Empty;
  logic             Byte_Ready;
  logic [0:63][7:0] Data_Block;
  logic             Enable;
  logic             Function;
  logic             Ready;

  int checks;
  int failures;

  sha_pad #(.Nl(64), .Nm(64)) dut (
    .clk(clk), .rst(rst), .Byte_In(Byte_In), .Byte_Valid(Byte_Valid),
    .Byte_Last(Byte_Last), .Msg_Empty(Msg_Empty), .Byte_Ready(Byte_Ready),
    .Data_Block(Data_Block), .Enable(Enable), .Function(Function), .Ready(Ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: 0x61+i ("abc..."), 1: constant 0x61, 2: byte index
  task automatic send_msg(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int to;
      to = 0;
      while (!Byte_Ready && to < 200) begin
        @(posedge clk); @(negedge clk);
        to++;
      end
      if (to >= 200) chk("byte_ready_timeout", 0, 1);
      Byte_Valid = 1'b1;
      Byte_Last  = (i == n - 1);
      Byte_In    = (mode == 0) ? 8'(8'h61 + i) : (mode == 1) ? 8'h61 : 8'(i);
      @(posedge clk); @(negedge clk);
      Byte_Valid = 1'b0;
      Byte_Last  = 1'b0;
    end
  endtask

  // waits for Enable, checks block/function, holds Ready low for 'hold' cycles
  task automatic wait_block(input string tag, input logic [0:63][7:0] exp,
                            input logic func, input int hold, output int lat);
    lat = 0;
    if (hold > 0) Ready = 1'b0;
    while (!Enable && lat < 300) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (lat >= 300) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_blk"}, Data_Block, exp);
      chk({tag, "_func"}, 512'(Function), 512'(func));
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); @(negedge clk);
        chk({tag, "_hold_blk"}, Data_Block, exp);
        chk({tag, "_hold_en"}, 512'(Enable), 512'(1));
        chk({tag, "_hold_brdy"}, 512'(Byte_Ready), 512'(0));
      end
      Ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({tag, "_en_drop"}, 512'(Enable), 512'(0));
      if (hold > 0) Ready = 1'b0;
    end
  endtask

  function automatic logic [0:63][7:0] with_len(input logic [0:63][7:0] b, input logic [63:0] bl);
    logic [0:63][7:0] r;
    r = b;
    for (int k = 0; k < 8; k++) r[56 + k] = bl[8*(7-k) +: 8];
    return r;
  endfunction

  logic [0:63][7:0] e;
  logic [0:63][7:0] abc_blk;
  int lat;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; Byte_In = '0; Byte_Valid = 1'b0; Byte_Last = 1'b0;
    Msg_Empty = 1'b0; Ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_en", 512'(Enable), 512'(0));
    chk("rst_func", 512'(Function), 512'(0));
    chk("rst_brdy", 512'(Byte_Ready), 512'(0));
    chk("rst_blk", Data_Block, 512'(0));
    rst = 1'b1;
    @(negedge clk); @(negedge clk);

    // "abc"
    abc_blk = '0;
    abc_blk[0] = 8'h61; abc_blk[1] = 8'h62; abc_blk[2] = 8'h63; abc_blk[3] = 8'h80;
    abc_blk = with_len(abc_blk, 64'h18);
    send_msg(3, 0);
    wait_block("abc", abc_blk, 1'b0, 0, lat);
    chk("abc_latency", 512'(lat), 512'(54));

    // 55 bytes: fits in one block
    e = '0;
    for (int i = 0; i < 55; i++) e[i] = 8'h61;
    e[55] = 8'h80;
    e = with_len(e, 64'h1B8);
    send_msg(55, 1);
    wait_block("m55", e, 1'b0, 0, lat);

    // 56 bytes: length spills into a second block
    e = '0;
    for (int i = 0; i < 56; i++) e[i] = 8'h61;
    e[56] = 8'h80;
    send_msg(56, 1);
    wait_block("m56_b1", e, 1'b0, 0, lat);
    e = with_len('0, 64'h1C0);
    wait_block("m56_b2", e, 1'b1, 0, lat);

    // 64 bytes with downstream back-pressure
    Ready = 1'b0;
    for (int i = 0; i < 64; i++) e[i] = 8'(i);
    send_msg(64, 2);
    wait_block("m64_b1", e, 1'b0, 10, lat);
    e = '0; e[0] = 8'h80;
    e = with_len(e, 64'h200);
    wait_block("m64_b2", e, 1'b1, 10, lat);
    Ready = 1'b1;

    // zero-length message, then a fresh message starts as a first block
    Msg_Empty = 1'b1;
    @(posedge clk); @(negedge clk);
    Msg_Empty = 1'b0;
    e = '0; e[0] = 8'h80;
    wait_block("empty", e, 1'b0, 0, lat);
    send_msg(3, 0);
    wait_block("abc2", abc_blk, 1'b0, 0, lat);

    // asynchronous reset while a block is presented
    Ready = 1'b0;
    send_msg(3, 0);
    lat = 0;
    while (!Enable && lat < 300) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("prerst_en", 512'(Enable), 512'(1));
    rst = 1'b0;
    #1;
    chk("midrst_en", 512'(Enable), 512'(0));
    chk("midrst_blk", Data_Block, 512'(0));
    chk("midrst_brdy", 512'(Byte_Ready), 512'(0));
    @(negedge clk);
    rst = 1'b1; Ready = 1'b1;
    @(negedge clk);
    send_msg(3, 0);
    wait_block("abc3", abc_blk, 1'b0, 0, lat);
    chk("abc3_latency", 512'(lat), 512'(54));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
